// File: rtl/alu_issue_ctrl.sv
// Instruction FIFO plus issue FSM that feeds the 1-bit ALU and returns results downstream.
// Optional result/error counters are enabled with `define ALU_ISSUE_CNT_EN.
module alu_issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_instr,
  output logic          alu_a,
  output logic          alu_b,
  output logic [2:0]    alu_op,
  input  logic          alu_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          res_data,
  output logic          res_err,
  output logic [2:0]    res_op,
  output logic [CW-1:0] fifo_level
`ifdef ALU_ISSUE_CNT_EN
  ,
  output logic [7:0]    done_cnt,
  output logic [7:0]    err_cnt
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t        state;
  logic [4:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [4:0]    head;
  logic          push;
  logic          pop;
  logic          hs;

  assign in_ready   = (count != CW'(DEPTH));
  assign fifo_level = count;
  assign head       = mem[rd_ptr];

  always_comb begin
    push = in_valid && in_ready;
    hs   = res_valid && res_ready;
    // A pop happens from IDLE, or from RESP in the same cycle the result is taken.
    pop  = (count != '0) && ((state == IDLE) || ((state == RESP) && hs));
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_instr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      state     <= IDLE;
      alu_a     <= 1'b0;
      alu_b     <= 1'b0;
      alu_op    <= '0;
      res_valid <= 1'b0;
      res_data  <= 1'b0;
      res_err   <= 1'b0;
      res_op    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;

      case (state)
        ISSUE: begin
          res_data  <= alu_out;
          res_err   <= 1'b0;
          res_op    <= alu_op;
          res_valid <= 1'b1;
          state     <= RESP;
        end
        default: begin
          if (pop) begin
            if (head[4]) begin
              res_data  <= 1'b0;
              res_err   <= 1'b1;
              res_op    <= head[4:2];
              res_valid <= 1'b1;
              state     <= RESP;
            end else begin
              alu_op    <= head[4:2];
              alu_a     <= head[1];
              alu_b     <= head[0];
              res_valid <= 1'b0;
              state     <= ISSUE;
            end
          end else if ((state == RESP) && hs) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef ALU_ISSUE_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_cnt <= '0;
      err_cnt  <= '0;
    end else if (hs) begin
      done_cnt <= done_cnt + 1'b1;
      if (res_err && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Upstream feeder for the 1-bit logic/arithmetic ALU stage.
- Accepts packed instruction words {op[2:0], a, b} over a valid/ready handshake and buffers them in a small FIFO.
- Issues one instruction at a time on the ALU operand/opcode lines, captures the ALU's combinational result, and presents it downstream with its own valid/ready handshake.
- Opcodes outside the supported set are rejected locally with an error flag and are never issued.

Parameters:
- DEPTH, 4, instruction FIFO entries; power of two, minimum 2.
- CW, $clog2(DEPTH+1), FIFO occupancy counter width (derived; do not override).

Ports:
- clk  input  1  single system clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- in_valid  input  1  instruction word present.
- in_ready  output  1  FIFO can accept a word; equals (occupancy != DEPTH).
- in_instr  input  5  [4:2]=op, [1]=a, [0]=b.
- alu_a  output  1  operand a to the ALU (registered).
- alu_b  output  1  operand b to the ALU (registered).
- alu_op  output  3  opcode to the ALU (registered).
- alu_out  input  1  combinational result returned from the ALU.
- res_valid  output  1  result available.
- res_ready  input  1  downstream accepts the result.
- res_data  output  1  captured result bit.
- res_err  output  1  result corresponds to an unsupported opcode.
- res_op  output  3  opcode the result belongs to.
- fifo_level  output  CW  current FIFO occupancy.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - FIFO emptied; fifo_level=0; FSM=IDLE.
  - alu_a=0, alu_b=0, alu_op=3'b000.
  - res_valid=0, res_data=0, res_err=0, res_op=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation discards any in-flight instruction and all buffered words.
- FIFO write: occurs on in_valid && in_ready. No write when full; in_instr is ignored while in_ready=0.
- FIFO read: occurs only on an FSM pop, defined below.
- Simultaneous push and pop: occupancy is unchanged and both actions take effect.
- Pointers wrap modulo DEPTH.
- Supported opcodes: 000 AND, 001 OR, 010 ADD, 011 SUB. Any op[2]=1 is unsupported.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE, FIFO empty: stay in IDLE.
  - IDLE, FIFO not empty: pop the head.
    - Supported op: load alu_a/alu_b/alu_op from the head word; go to ISSUE.
    - Unsupported op: alu_* keep their previous values; res_data<=0, res_err<=1, res_op<=op, res_valid<=1; go to RESP.
  - ISSUE (exactly 1 cycle): the ALU settles combinationally. At the end of the cycle: res_data<=alu_out, res_err<=0, res_op<=alu_op, res_valid<=1; go to RESP.
  - RESP: hold res_* stable while res_ready=0. On res_valid && res_ready:
    - FIFO not empty: pop the next head the same cycle and proceed as from IDLE (go to ISSUE or RESP). res_valid stays high only if the next op is unsupported; otherwise res_valid drops for the ISSUE cycle.
    - FIFO empty: res_valid<=0; go to IDLE.
- Timing:
  - A word written at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1.
  - alu_* are valid after edge N+1.
  - res_valid rises after edge N+2.
  - Sustained throughput with res_ready held at 1: one supported op per 2 cycles; one unsupported op per cycle.
- alu_a, alu_b and alu_op change only on a pop of a supported op; they hold their values otherwise.
- The FIFO entry is the only storage for an instruction; no instruction is lost under backpressure.

Optional Feature:
- Macro: ALU_ISSUE_CNT_EN.
- Defined:
  - Adds output port done_cnt [7:0]: count of result handshakes (res_valid && res_ready), including error results.
  - Reset value 0; wraps 255 -> 0.
  - Adds output port err_cnt [7:0]: counts error results only; saturates at 255.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset, then push {010,1,1} with res_ready=1 -> alu_op=010, a=1, b=1 one cycle after the push; res_valid=1, res_data=alu_out (model 0), res_err=0, res_op=010 two cycles after the push.
- Push 4 words with res_ready=0 and DEPTH=4 -> after the first pop, fifo_level reaches 3 and then 4 once more words arrive; in_ready=0 when full; a 5th word held on in_instr is not accepted until res_ready=1.
- Push {101,1,0} -> ALU lines unchanged, res_valid=1 with res_err=1, res_data=0, res_op=101 one cycle after the pop; alu_op never equals 101.
- Back-to-back AND, OR, SUB with res_ready=1 -> res_valid pulses every 2 cycles; res_op sequence 000, 001, 011 with matching ALU results.
- Assert rst_n=0 while in RESP with 2 words buffered -> next cycle fifo_level=0, res_valid=0, alu_op=000, in_ready=1.
- With ALU_ISSUE_CNT_EN defined: 257 completed ops, 3 of them unsupported -> done_cnt=1, err_cnt=3.
